// File: rtl/mimosa_pkg.sv
// Shared constants for the mimosa behaviour model front end: stimulus channel
// indices and the default split between edge and level channels.
package mimosa_pkg;

    localparam int STIM_N      = 10;

    localparam int STIM_TICKLE = 0;
    localparam int STIM_PLAY   = 1;
    localparam int STIM_TALK   = 2;
    localparam int STIM_CALM   = 3;
    localparam int STIM_FEED   = 4;
    localparam int STIM_COOL   = 5;
    localparam int STIM_HOT    = 6;
    localparam int STIM_QUIET  = 7;
    localparam int STIM_LOUD   = 8;
    localparam int STIM_BRIGHT = 9;

    // Set bits are environment (level) channels, clear bits are button (edge) channels.
    localparam logic [STIM_N-1:0] DEFAULT_LEVEL_MASK = 10'b11_1110_0000;

endpackage

// File: rtl/stimulus_debouncer.sv
// One stimulus channel: two-flop synchroniser, debounce counter and the
// debounced level with its one-cycle rise indication.
module stimulus_debouncer
    import mimosa_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic db,
    output logic rise
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       db_q, db_d;
    logic       db_dly_q, db_dly_d;
    logic [7:0] cnt_q, cnt_d;

    // Synchroniser shift and debounce decision: the level only moves after the
    // synchronised input has disagreed with it for DEBOUNCE_CYCLES cycles in a row.
    always_comb begin
        sync1_d  = raw_in;
        sync2_d  = sync1_q;
        db_dly_d = db_q;
        db_d     = db_q;
        cnt_d    = cnt_q;
        if (sync2_q == db_q) begin
            cnt_d = 8'd0;
        end else if (cnt_q == CNT_LAST) begin
            db_d  = sync2_q;
            cnt_d = 8'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Channel state registers, all cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            db_q     <= db_d;
            db_dly_q <= db_dly_d;
            cnt_q    <= cnt_d;
        end
    end

    assign db   = db_q;
    assign rise = db_q & ~db_dly_q;

endmodule

// File: rtl/stimulus_conditioner.sv
// Conditions raw pad bits into the per-tick stimuli bus: edge channels latch a
// press until the next model tick, level channels are sampled on each tick.
module stimulus_conditioner
    import mimosa_pkg::*;
#(
    parameter int              N               = 10,
    parameter int              DEBOUNCE_CYCLES = 200,
    parameter logic [N-1:0]    LEVEL_MASK      = DEFAULT_LEVEL_MASK
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] raw_in,
    input  logic         tick,
    output logic [N-1:0] stimuli_out,
    output logic         new_stimulus,
    output logic [7:0]   drop_cnt
);

    logic [N-1:0] db;
    logic [N-1:0] rise;

    logic [N-1:0] stim_q, stim_d;
    logic [N-1:0] pend_q, pend_d;
    logic         new_q, new_d;
    logic [7:0]   drop_q, drop_d;
    logic         drop_any;

    for (genvar g = 0; g < N; g++) begin : gen_ch
        stimulus_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .raw_in(raw_in[g]),
            .db    (db[g]),
            .rise  (rise[g])
        );
    end

    // Per-channel tick update, pending capture and drop detection; a rise on the
    // tick cycle goes straight to the output so it is never counted as a drop.
    always_comb begin
        stim_d   = stim_q;
        pend_d   = pend_q;
        drop_any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (LEVEL_MASK[i]) begin
                pend_d[i] = 1'b0;
                if (tick) begin
                    stim_d[i] = db[i];
                end
            end else if (tick) begin
                stim_d[i] = pend_q[i] | rise[i];
                pend_d[i] = 1'b0;
            end else if (rise[i]) begin
                pend_d[i] = 1'b1;
                if (pend_q[i]) begin
                    drop_any = 1'b1;
                end
            end
        end
        drop_d = drop_q;
        if (drop_any && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
        new_d = tick && ((stim_d != stim_q) || (|(stim_d & ~LEVEL_MASK)));
    end

    // Output, pending and drop counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stim_q <= '0;
            pend_q <= '0;
            new_q  <= 1'b0;
            drop_q <= 8'd0;
        end else begin
            stim_q <= stim_d;
            pend_q <= pend_d;
            new_q  <= new_d;
            drop_q <= drop_d;
        end
    end

    assign stimuli_out  = stim_q;
    assign new_stimulus = new_q;
    assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_stimulus_conditioner.sv
// Directed bench for stimulus_conditioner with a 4-cycle debounce and a tick on
// every 16th clock edge; expected values are worked out by hand per scenario.
module tb_stimulus_conditioner;

    localparam int N = 10;

    logic         clk;
    logic         rst;
    logic [N-1:0] raw_in;
    logic         tick;
    logic [N-1:0] stimuli_out;
    logic         new_stimulus;
    logic [7:0]   drop_cnt;

    int test_count;
    int fail_count;
    int phase;
    int ns_pulses;
    int stim0_high;
    logic [N-1:0] raw_bits;

    stimulus_conditioner #(
        .N              (N),
        .DEBOUNCE_CYCLES(4),
        .LEVEL_MASK     (10'b11_1110_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .raw_in      (raw_in),
        .tick        (tick),
        .stimuli_out (stimuli_out),
        .new_stimulus(new_stimulus),
        .drop_cnt    (drop_cnt)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] value);
        raw_bits = value;
        raw_in   = value;
    endtask

    // Advance n edges; tick is high on the edge taken while phase==15.
    task automatic runCycles(input int n);
        for (int k = 0; k < n; k++) begin
            tick = (phase == 15);
            @(posedge clk);
            #1;
            tick  = 1'b0;
            phase = (phase + 1) % 16;
            if (new_stimulus) ns_pulses++;
            if (stimuli_out[0]) stim0_high++;
        end
    endtask

    task automatic alignPhase(input int target);
        while (phase != target) runCycles(1);
    endtask

    task automatic runToTick();
        alignPhase(15);
        runCycles(1);
    endtask

    // Two debounced rises on the feed channel inside one tick period.
    task automatic doublePress();
        alignPhase(0);
        for (int p = 0; p < 16; p++) begin
            raw_bits[4] = ((p < 4) || ((p >= 8) && (p < 12)));
            applyStimulus(raw_bits);
            runCycles(1);
        end
        raw_bits[4] = 1'b0;
        applyStimulus(raw_bits);
    endtask

    initial begin
        test_count = 0;
        fail_count = 0;
        phase      = 0;
        ns_pulses  = 0;
        stim0_high = 0;
        tick       = 1'b0;
        rst        = 1'b1;
        applyStimulus(10'h3FF);

        // Reset held with every input high.
        runCycles(20);
        checkOutput("reset_stimuli", 32'(stimuli_out), 32'h0);
        checkOutput("reset_drop", 32'(drop_cnt), 32'h0);
        checkOutput("reset_new", 32'(new_stimulus), 32'h0);
        rst = 1'b0;
        runCycles(5);
        checkOutput("db_after_5", 32'(dut.db), 32'h0);
        runCycles(1);
        checkOutput("db_after_6", 32'(dut.db), 32'h3FF);
        runToTick();
        checkOutput("all_high_stimuli", 32'(stimuli_out), 32'h3FF);
        checkOutput("all_high_new", 32'(new_stimulus), 32'h1);
        runToTick();
        checkOutput("edges_expire", 32'(stimuli_out), 32'h3E0);
        checkOutput("edges_expire_new", 32'(new_stimulus), 32'h1);
        checkOutput("no_drop_yet", 32'(drop_cnt), 32'h0);
        applyStimulus(10'h000);
        runCycles(8);
        runToTick();
        checkOutput("all_low_stimuli", 32'(stimuli_out), 32'h0);
        runToTick();
        checkOutput("idle_new", 32'(new_stimulus), 32'h0);

        // Short glitch on tickle is rejected.
        alignPhase(0);
        ns_pulses = 0;
        raw_bits[0] = 1'b1;
        applyStimulus(raw_bits);
        runCycles(3);
        raw_bits[0] = 1'b0;
        applyStimulus(raw_bits);
        runCycles(29);
        checkOutput("glitch_stimuli", 32'(stimuli_out), 32'h0);
        checkOutput("glitch_pulses", 32'(ns_pulses), 32'h0);

        // Ten-cycle press on tickle is delivered for one tick period.
        alignPhase(0);
        ns_pulses  = 0;
        stim0_high = 0;
        raw_bits[0] = 1'b1;
        applyStimulus(raw_bits);
        runCycles(10);
        raw_bits[0] = 1'b0;
        applyStimulus(raw_bits);
        runCycles(6);
        checkOutput("press_stimuli", 32'(stimuli_out), 32'h001);
        checkOutput("press_new", 32'(new_stimulus), 32'h1);
        runCycles(16);
        checkOutput("press_expired", 32'(stimuli_out), 32'h0);
        checkOutput("press_high_cycles", 32'(stim0_high), 32'd16);
        checkOutput("press_pulses", 32'(ns_pulses), 32'd2);

        // Double presses on feed: one delivery each, drop counter saturates.
        for (int k = 1; k <= 300; k++) begin
            doublePress();
            if (k == 1) begin
                checkOutput("double_stimuli", 32'(stimuli_out), 32'h010);
                checkOutput("double_drop", 32'(drop_cnt), 32'd1);
                checkOutput("double_new", 32'(new_stimulus), 32'h1);
            end
            runCycles(16);
            if (k == 1) begin
                checkOutput("double_expired", 32'(stimuli_out), 32'h0);
            end
            if (k == 254) begin
                checkOutput("drop_254", 32'(drop_cnt), 32'd254);
            end
        end
        checkOutput("drop_saturated", 32'(drop_cnt), 32'd255);

        // Rise on talk lands exactly on a tick edge.
        alignPhase(9);
        raw_bits[2] = 1'b1;
        applyStimulus(raw_bits);
        runCycles(6);
        runCycles(1);
        checkOutput("same_tick_stimuli", 32'(stimuli_out), 32'h004);
        checkOutput("same_tick_new", 32'(new_stimulus), 32'h1);
        checkOutput("same_tick_pend", 32'(dut.pend_q[2]), 32'h0);
        checkOutput("same_tick_drop", 32'(drop_cnt), 32'd255);
        runToTick();
        checkOutput("same_tick_not_deferred", 32'(stimuli_out), 32'h0);
        raw_bits[2] = 1'b0;
        applyStimulus(raw_bits);
        runCycles(32);

        // Held level on the hot channel.
        alignPhase(0);
        raw_bits[6] = 1'b1;
        applyStimulus(raw_bits);
        runCycles(16);
        checkOutput("level_rise", 32'(stimuli_out), 32'h040);
        checkOutput("level_rise_new", 32'(new_stimulus), 32'h1);
        runCycles(16);
        checkOutput("level_hold", 32'(stimuli_out), 32'h040);
        checkOutput("level_hold_new", 32'(new_stimulus), 32'h0);
        raw_bits[6] = 1'b0;
        applyStimulus(raw_bits);
        runCycles(16);
        checkOutput("level_fall", 32'(stimuli_out), 32'h0);
        checkOutput("level_fall_new", 32'(new_stimulus), 32'h1);
        runCycles(16);
        checkOutput("level_idle_new", 32'(new_stimulus), 32'h0);

        // Reset with an event pending and a debounce in progress.
        alignPhase(0);
        raw_bits[1] = 1'b1;
        applyStimulus(raw_bits);
        runCycles(4);
        raw_bits[3] = 1'b1;
        applyStimulus(raw_bits);
        runCycles(4);
        checkOutput("pre_reset_pend", 32'(dut.pend_q[1]), 32'h1);
        checkOutput("pre_reset_cnt", 32'(dut.gen_ch[3].u_deb.cnt_q), 32'd2);
        rst = 1'b1;
        applyStimulus(10'h000);
        runCycles(2);
        checkOutput("mid_reset_pend", 32'(dut.pend_q), 32'h0);
        checkOutput("mid_reset_drop", 32'(drop_cnt), 32'h0);
        rst = 1'b0;
        runToTick();
        checkOutput("post_reset_stimuli", 32'(stimuli_out), 32'h0);
        checkOutput("post_reset_new", 32'(new_stimulus), 32'h0);
        checkOutput("post_reset_drop", 32'(drop_cnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
